// File: rtl/ks_sub64_seq_pkg.sv
// Shared arithmetic constants and FSM state type for the sequential 64-bit subtractor.
package ks_arith_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned HALF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

endpackage

// File: rtl/ks_sub64_seq_if.sv
// Operand/result handshake bundle for ks_sub64_seq; slave is the subtractor side.
interface ks_sub64_seq_if;
    import ks_arith_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] inp_a;
    logic [WORD_W-1:0] inp_b;
    logic              bin;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_d;
    logic              out_borrow;
    logic              out_ovf;

    modport master (
        output in_valid, inp_a, inp_b, bin, out_ready,
        input  in_ready, out_valid, out_d, out_borrow, out_ovf
    );

    modport slave (
        input  in_valid, inp_a, inp_b, bin, out_ready,
        output in_ready, out_valid, out_d, out_borrow, out_ovf
    );

endinterface

// File: rtl/ks_sub64_seq_add32.sv
// Combinational 32-bit Kogge-Stone adder; carry-in is folded into bit 0's generate.
module ks_add32
    import ks_arith_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              cout
);

    localparam int unsigned LEVELS = $clog2(HALF_W);

    logic [HALF_W-1:0] p0;
    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;

    assign p0 = a ^ b;

    // Bits below the current span already hold final prefixes, so shifting in zeros is harmless.
    always_comb begin
        g = (a & b) | {{(HALF_W-1){1'b0}}, p0[0] & cin};
        p = p0;
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            g = g | (p & (g << (1 << lvl)));
            p = p & (p << (1 << lvl));
        end
    end

    assign s    = p0 ^ {g[HALF_W-2:0], cin};
    assign cout = g[HALF_W-1];

endmodule

// File: rtl/ks_sub64_seq.sv
// Sequential 64-bit subtractor (A - B - bin) using one 32-bit Kogge-Stone adder over two passes.
// Optional signed-overflow flag: define KS_SUB64_OVF_EN.
module ks_sub64_seq
    import ks_arith_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ks_sub64_seq_if.slave  bus
);

    state_t            state;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic              bin_q;
    logic              c32_q;
    logic [WORD_W-1:0] d_q;
    logic              borrow_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_cin;
    logic [HALF_W-1:0] add_s;
    logic              add_cout;

    // Subtraction as a + ~b + ~bin; the high pass chains the low pass carry.
    always_comb begin
        if (state == HI) begin
            add_a   = a_q[WORD_W-1:HALF_W];
            add_b   = ~b_q[WORD_W-1:HALF_W];
            add_cin = c32_q;
        end else begin
            add_a   = a_q[HALF_W-1:0];
            add_b   = ~b_q[HALF_W-1:0];
            add_cin = ~bin_q;
        end
    end

    ks_add32 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

`ifdef KS_SUB64_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bin_q       <= 1'b0;
            c32_q       <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef KS_SUB64_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.inp_a;
                        b_q        <= bus.inp_b;
                        bin_q      <= bus.bin;
                        in_ready_q <= 1'b0;
                        state      <= LO;
                    end
                end
                LO: begin
                    d_q[HALF_W-1:0] <= add_s;
                    c32_q           <= add_cout;
                    state           <= HI;
                end
                HI: begin
                    d_q[WORD_W-1:HALF_W] <= add_s;
                    borrow_q             <= ~add_cout;
`ifdef KS_SUB64_OVF_EN
                    ovf_q <= (a_q[WORD_W-1] != b_q[WORD_W-1]) &
                             (add_s[HALF_W-1] != a_q[WORD_W-1]);
`endif
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_d      = d_q;
    assign bus.out_borrow = borrow_q;
`ifdef KS_SUB64_OVF_EN
    assign bus.out_ovf    = ovf_q;
`else
    assign bus.out_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sub64_seq.sv
// Self-checking bench for ks_sub64_seq: arithmetic reference model, directed literals, random traffic.
module tb_ks_sub64_seq;

`ifdef KS_SUB64_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ks_sub64_seq_if bus ();

    ks_sub64_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] d;
        logic        bor;
        logic        ovf;
    } exp_t;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   cyc;
    int   acc_cyc;

    // Reference: plain wide arithmetic, unsigned for difference/borrow, signed for overflow.
    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic bi);
        exp_t               m;
        logic [64:0]        u;
        logic signed [65:0] sr;
        u  = {1'b0, a} - {1'b0, b} - {64'b0, bi};
        sr = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'b0, bi});
        m.d   = u[63:0];
        m.bor = u[64];
        m.ovf = OVF_EN && (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
        return m;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction tracker: accepts and completed handshakes as seen at the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cyc     = 0;
            acc_cyc = 0;
        end else begin
            cyc++;
            if (bus.out_valid && bus.out_ready && q.size() != 0)
                void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.inp_a, bus.inp_b, bus.bin));
                acc_cyc = cyc;
            end
        end
    end

    task automatic compare_loop();
        bit ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev = (q.size() != 0) && ((cyc - acc_cyc) >= 2);
                check("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
                check("out_valid", 64'(bus.out_valid), 64'(ev));
                if (ev && bus.out_valid) begin
                    check("out_d", bus.out_d, q[0].d);
                    check("out_borrow", 64'(bus.out_borrow), 64'(q[0].bor));
                    check("out_ovf", 64'(bus.out_ovf), 64'(q[0].ovf));
                end
            end
        end
    endtask

    // Present operands once the block is ready; returns on the negedge after the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bi);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 64'd1, 64'd0);
        bus.inp_a    = a;
        bus.inp_b    = b;
        bus.bin      = bi;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_lit(input logic [63:0] a, input logic [63:0] b, input logic bi,
                           input logic [63:0] ed, input logic eb, input logic eo);
        int lat = 0;
        int n   = 0;
        send(a, b, bi);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        check("lit_d", bus.out_d, ed);
        check("lit_borrow", 64'(bus.out_borrow), 64'(eb));
        check("lit_ovf", 64'(bus.out_ovf), 64'(eo));
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int seen;
        int n;
        logic [63:0] ra;
        logic [63:0] rb;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inp_a     = '0;
        bus.inp_b     = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        fork
            compare_loop();
        join_none

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_d", bus.out_d, 64'd0);
        check("rst_out_borrow", 64'(bus.out_borrow), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while the high half is being computed: result must be dropped.
        send(64'hFFFF_0000_1234_5678, 64'h0000_0001_0000_0001, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_d", bus.out_d, 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_borrow", 64'(bus.out_borrow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        run_lit(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
        run_lit(64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0);
        run_lit(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        run_lit(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_lit(64'd3, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_lit(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, OVF_EN);
        run_lit(64'd7, 64'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        // Backpressure with new operands pulsed while the result is held.
        bus.out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.inp_a    = {$urandom, $urandom};
            bus.inp_b    = {$urandom, $urandom};
            bus.bin      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_out_d", bus.out_d, 64'h0246_8ACF_1357_9BCF);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);

        // Random traffic: operands change every cycle, in_valid and out_ready toggle freely.
        for (int i = 0; i < 1500; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: rb = ra;
                2: begin
                    ra = 64'($urandom_range(0, 15));
                    rb = 64'($urandom_range(0, 15));
                end
                default: begin
                    ra = {1'($urandom_range(0, 1)), 63'($urandom_range(0, 3))} - 64'($urandom_range(0, 2));
                    rb = {1'($urandom_range(0, 1)), 63'($urandom_range(0, 3))} + 64'($urandom_range(0, 2));
                end
            endcase
            bus.inp_a     = ra;
            bus.inp_b     = rb;
            bus.bin       = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("final_drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
